// File: rtl/xrv1_tcm_arb_pkg.sv
// Shared types and helpers for the imem/dmem TCM arbiter.
package xrv1_tcm_arb_pkg;

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/xrv1_tag_fifo.sv
// In-order tag FIFO: pop_data is the oldest entry; push/pop take effect at the clock edge.
// No bypass; a push while full or a pop while empty is ignored.
module xrv1_tag_fifo
  import xrv1_tcm_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/xrv1_tcm_arb.sv
// Shares one TCM request/response channel between imem and dmem, routing responses back by source tag.
// Zero-latency combinational request path; stalls both requesters when MAX_OUTST requests are outstanding.
module xrv1_tcm_arb
  import xrv1_tcm_arb_pkg::*;
#(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_req_vld_i,
  output logic        imem_req_rdy_o,
  input  logic [31:0] imem_req_addr_i,
  output logic        imem_resp_vld_o,
  output logic [31:0] imem_resp_data_o,
  input  logic        dmem_req_vld_i,
  output logic        dmem_req_rdy_o,
  input  logic [31:0] dmem_req_addr_i,
  input  logic        dmem_req_w_en_i,
  input  logic [3:0]  dmem_req_w_be_i,
  input  logic [31:0] dmem_req_w_data_i,
  output logic        dmem_resp_vld_o,
  output logic [31:0] dmem_resp_r_data_o,
  output logic        dmem_resp_err_o,
  output logic        mem_req_vld_o,
  input  logic        mem_req_rdy_i,
  output logic [31:0] mem_req_addr_o,
  output logic        mem_req_w_en_o,
  output logic [3:0]  mem_req_w_be_o,
  output logic [31:0] mem_req_w_data_o,
  input  logic        mem_resp_vld_i,
  input  logic [31:0] mem_resp_data_i,
  input  logic        mem_resp_err_i
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  logic             lock_vld;
  src_e             lock_src;
  logic [STV_W-1:0] starve_cnt;

  logic             gnt_vld;
  src_e             gnt_src;
  logic             req_hs;
  logic             gnt_dmem;

  logic             tag_full;
  logic             tag_empty;
  logic [CNT_W-1:0] tag_cnt;
  logic [0:0]       push_tag;
  logic [0:0]       tag_head;
  src_e             resp_src;
  logic             resp_pop;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_DMEM;
    if (lock_vld) begin
      gnt_src = lock_src;
      gnt_vld = (lock_src == SRC_DMEM) ? dmem_req_vld_i : imem_req_vld_i;
    end else if (imem_req_vld_i && dmem_req_vld_i) begin
      gnt_vld = 1'b1;
      gnt_src = (starve_cnt == STV_MAX) ? SRC_IMEM : SRC_DMEM;
    end else if (imem_req_vld_i) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_IMEM;
    end else if (dmem_req_vld_i) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_DMEM;
    end
  end

  assign gnt_dmem         = (gnt_src == SRC_DMEM);
  assign mem_req_vld_o    = gnt_vld & ~tag_full & ~rst_i;
  assign req_hs           = mem_req_vld_o & mem_req_rdy_i;
  assign imem_req_rdy_o   = req_hs & ~gnt_dmem;
  assign dmem_req_rdy_o   = req_hs & gnt_dmem;
  assign mem_req_addr_o   = gnt_dmem ? dmem_req_addr_i : imem_req_addr_i;
  assign mem_req_w_en_o   = gnt_dmem & dmem_req_w_en_i;
  assign mem_req_w_be_o   = gnt_dmem ? dmem_req_w_be_i : 4'b0000;
  assign mem_req_w_data_o = gnt_dmem ? dmem_req_w_data_i : 32'h0;

  // A stalled grant is pinned so the offered payload cannot switch source mid-request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_vld <= 1'b0;
      lock_src <= SRC_IMEM;
    end else if (mem_req_vld_o && !mem_req_rdy_i) begin
      lock_vld <= 1'b1;
      lock_src <= gnt_src;
    end else if (req_hs) begin
      lock_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (!imem_req_vld_i || (req_hs && !gnt_dmem)) begin
      starve_cnt <= '0;
    end else if (req_hs && starve_cnt != STV_MAX) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  assign push_tag = gnt_src;

  xrv1_tag_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (req_hs),
    .push_data (push_tag),
    .pop       (resp_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_cnt)
  );

  // Responses with no recorded tag (e.g. in flight across reset) are dropped.
  assign resp_pop           = mem_resp_vld_i & ~tag_empty & ~rst_i;
  assign resp_src           = src_e'(tag_head);
  assign imem_resp_vld_o    = resp_pop & (resp_src == SRC_IMEM);
  assign dmem_resp_vld_o    = resp_pop & (resp_src == SRC_DMEM);
  assign imem_resp_data_o   = imem_resp_vld_o ? mem_resp_data_i : 32'h0;
  assign dmem_resp_r_data_o = dmem_resp_vld_o ? mem_resp_data_i : 32'h0;
  assign dmem_resp_err_o    = mem_resp_err_i & dmem_resp_vld_o;

  assert property (@(posedge clk_i) disable iff (rst_i) tag_cnt <= CNT_W'(MAX_OUTST));

endmodule

// File: doc/xrv1_tcm_arb.md
Name: xrv1_tcm_arb

Overview:
- Shares one single-ported TCM request/response channel between the core's instruction-fetch port (imem) and its load/store port (dmem).
- Picks one requester per cycle and forwards its request. Records the source of each accepted request in an in-order tag FIFO, then routes each memory response back to the requester that issued it.
- Sits between xrv1_core and a unified TCM in single-port SoC and simulation tops.

Parameters:
- MAX_OUTST, 4: maximum accepted-but-unanswered memory requests; tag FIFO depth; power of two, >= 2.
- STARVE_LIMIT, 3: consecutive dmem grants taken while imem was waiting, after which imem is forced; >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- imem_req_vld_i  in  1  fetch request valid
- imem_req_rdy_o  out  1  fetch request accepted
- imem_req_addr_i  in  32  fetch address
- imem_resp_vld_o  out  1  fetch response valid
- imem_resp_data_o  out  32  fetch data
- dmem_req_vld_i  in  1  data request valid
- dmem_req_rdy_o  out  1  data request accepted
- dmem_req_addr_i  in  32  data address
- dmem_req_w_en_i  in  1  write enable
- dmem_req_w_be_i  in  4  byte enables
- dmem_req_w_data_i  in  32  write data
- dmem_resp_vld_o  out  1  data response valid
- dmem_resp_r_data_o  out  32  load data
- dmem_resp_err_o  out  1  data access error
- mem_req_vld_o  out  1  TCM request valid
- mem_req_rdy_i  in  1  TCM ready
- mem_req_addr_o  out  32  TCM address
- mem_req_w_en_o  out  1  TCM write enable; forced 0 for imem
- mem_req_w_be_o  out  4  TCM byte enables; forced 0 for imem
- mem_req_w_data_o  out  32  TCM write data
- mem_resp_vld_i  in  1  TCM response valid
- mem_resp_data_i  in  32  TCM response data
- mem_resp_err_i  in  1  TCM response error

Behaviour:
- Reset:
  - All vld/rdy outputs are 0 while rst_i is high.
  - Tag FIFO is emptied, lock register cleared, starvation counter set to 0.
- TCM contract: every request, read or write, produces exactly one response. Responses return in order, at least 1 cycle after the handshake.
- Grant and forwarding:
  - Request path is combinational: zero added latency from the grant to mem_req_*.
  - A handshake occurs when mem_req_vld_o and mem_req_rdy_i are both high. Only the granted requester sees rdy_o = mem_req_rdy_i; the other sees rdy_o = 0.
- Arbitration (only when no lock is held):
  - Only one requester valid: grant it.
  - Both valid: grant dmem, unless starve_cnt == STARVE_LIMIT, in which case grant imem.
- Starvation counter:
  - Increments on each dmem handshake while imem_req_vld_i is high.
  - Clears on any imem handshake, or on any cycle where imem_req_vld_i is low.
  - Saturates at STARVE_LIMIT.
- Lock:
  - If mem_req_vld_o is high and mem_req_rdy_i is low, store the granted source in a lock register.
  - While locked, that source stays granted regardless of the other requester or the counter, until its handshake clears the lock.
  - The requester protocol requires payload to be held stable while valid.
- Flow control:
  - When FIFO count == MAX_OUTST: mem_req_vld_o = 0 and both rdy_o = 0. Any held lock is kept.
  - A pop in the same cycle does not free a slot for a push in that cycle; no combinational path from mem_resp_vld_i to any rdy.
- Tag push: on handshake, push the source (SRC_IMEM / SRC_DMEM).
- Response routing:
  - On mem_resp_vld_i with FIFO non-empty, pop. Assert exactly one of imem_resp_vld_o / dmem_resp_vld_o, in the same cycle (combinational).
  - Response data outputs carry mem_resp_data_i when their valid is high, else 0.
  - dmem_resp_err_o = mem_resp_err_i & dmem_resp_vld_o.
  - mem_resp_err_i on an imem-tagged response is dropped.
- Spurious response: mem_resp_vld_i with the FIFO empty, e.g. in flight across a reset, is discarded; no resp_vld_o is raised.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. Pointers wrap modulo MAX_OUTST.

Decomposition:
- xrv1_tcm_arb_pkg:
  - enum src_e {SRC_IMEM = 1'b0, SRC_DMEM = 1'b1}
  - function clog2-based pointer width
- Sub-module xrv1_tag_fifo:
  - Width 1, depth MAX_OUTST, synchronous reset.
  - push/pop/full/empty/count.
  - No same-cycle bypass.

Test Plan:
- Imem-only: fetch 0x100, 0x104, mem_req_rdy_i = 1, TCM latency 1 → mem_req_addr_o follows in order; imem_resp_vld_o on cycles 2 and 3 with matching data; dmem_resp_vld_o stays 0.
- Contention: both valid every cycle for 8 cycles, STARVE_LIMIT = 3 → grant sequence D, D, D, I, D, D, D, I.
- Lock: dmem requests write 0xDEADBEEF, be = 4'b0011, mem_req_rdy_i = 0 for 3 cycles, imem raised in cycle 1 → mem_req_* holds the dmem write for all 4 cycles; imem_req_rdy_o = 0 until the cycle after the dmem handshake.
- Full: MAX_OUTST = 4, TCM withholds responses, 4 dmem reads accepted → 5th request sees rdy 0. One response arrives → the 5th is accepted on the following cycle, not the same cycle.
- Routing and error: interleaved I, D, I handshakes; responses with err = 0, 1, 1 → imem_resp_vld_o, dmem_resp_vld_o with dmem_resp_err_o = 1, then imem_resp_vld_o with no error output.
- Reset mid-operation: 2 requests outstanding, rst_i pulsed 1 cycle, stale response arrives next → no resp_vld_o; FIFO empty; the next fetch after reset completes normally.
